// File: rtl/rv_trace_capture_pkg.sv
// Shared types and widths for the RV32 commit-stream trace capture block.
package rv_trace_capture_pkg;
  localparam int unsigned TRACE_W     = 134;
  localparam int unsigned ILA_PROBE_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DRAIN = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic [31:0] ts;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        we;
  } trace_entry_t;
endpackage

// File: rtl/rv_trace_capture_if.sv
// Commit stream from the retire stage plus the valid/ready drain port.
interface rv_trace_capture_if;
  import rv_trace_capture_pkg::*;

  logic               commit_valid;
  logic [31:0]        commit_pc;
  logic [31:0]        commit_instr;
  logic [4:0]         commit_rd;
  logic               commit_we;
  logic [31:0]        commit_wdata;
  logic               rd_valid;
  logic               rd_ready;
  logic [TRACE_W-1:0] rd_data;

  modport master (
    output commit_valid, commit_pc, commit_instr, commit_rd, commit_we, commit_wdata,
    output rd_ready,
    input  rd_valid, rd_data
  );

  modport slave (
    input  commit_valid, commit_pc, commit_instr, commit_rd, commit_we, commit_wdata,
    input  rd_ready,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/rv_trace_capture_trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port with enable, no reset.
module rv_trace_capture_trace_ram
  import rv_trace_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = TRACE_W,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/rv_trace_capture.sv
// Commit-stream trace buffer: circular capture with PC trigger and pre-trigger window,
// ILA probe packing and a valid/ready drain port.
module rv_trace_capture
  import rv_trace_capture_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned PRE_TRIG = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rv_trace_capture_if.slave        bus,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [31:0]              trig_pc,
  output logic [1:0]               state_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [ILA_PROBE_W-1:0]   ila_probe0,
  output logic [31:0]              ila_trig
);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned POST_N = DEPTH - PRE_TRIG;
  localparam int unsigned PAD_W  = ILA_PROBE_W - 2 - AW - CW - 1 - TRACE_W;

  trace_state_e       state, state_nx;
  logic [31:0]        ts;
  logic [AW-1:0]      wr_ptr, rd_addr, ptr_nx;
  logic [CW-1:0]      written, written_nx, post_cnt, issue_left;
  logic               q_valid;
  logic [TRACE_W-1:0] ram_q;
  trace_entry_t       cur;
  logic               store, trig_hit, post_done, out_take, issue, last_xfer;

  always_comb begin
    cur.ts    = ts;
    cur.pc    = bus.commit_pc;
    cur.instr = bus.commit_instr;
    cur.wdata = bus.commit_wdata;
    cur.rd    = bus.commit_rd;
    cur.we    = bus.commit_we;

    store      = bus.commit_valid && !arm && (state == ST_ARMED || state == ST_POST);
    trig_hit   = bus.commit_valid && !arm && state == ST_ARMED && trig_en &&
                 bus.commit_pc == trig_pc;
    post_done  = (trig_hit && POST_N == 1) ||
                 (store && state == ST_POST && post_cnt == CW'(POST_N - 1));
    ptr_nx     = wr_ptr + AW'(1);
    written_nx = (written == CW'(DEPTH)) ? written : written + CW'(1);

    // Two-stage drain pipe: RAM output register (q_valid) feeds the rd_data register;
    // the RAM read is only enabled when the RAM register can move on, so a stall holds both.
    out_take  = !bus.rd_valid || bus.rd_ready;
    issue     = state == ST_DRAIN && !arm && issue_left != '0 && (!q_valid || out_take);
    last_xfer = state == ST_DRAIN && issue_left == '0 && !q_valid &&
                bus.rd_valid && bus.rd_ready;

    state_nx = state;
    if (arm) begin
      state_nx = ST_ARMED;
    end else begin
      case (state)
        ST_ARMED: if (trig_hit)  state_nx = post_done ? ST_DRAIN : ST_POST;
        ST_POST:  if (post_done) state_nx = ST_DRAIN;
        ST_DRAIN: if (last_xfer) state_nx = ST_IDLE;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ts           <= '0;
      wr_ptr       <= '0;
      written      <= '0;
      post_cnt     <= '0;
      rd_addr      <= '0;
      issue_left   <= '0;
      q_valid      <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
      ila_probe0   <= '0;
      ila_trig     <= '0;
    end else begin
      state      <= state_nx;
      ts         <= ts + 32'd1;
      ila_probe0 <= {state, wr_ptr, written, trig_hit, cur, {PAD_W{1'b0}}};
      ila_trig   <= {31'd0, trig_hit};
      if (arm) begin
        wr_ptr       <= '0;
        written      <= '0;
        post_cnt     <= '0;
        issue_left   <= '0;
        q_valid      <= 1'b0;
        bus.rd_valid <= 1'b0;
      end else begin
        if (store) begin
          wr_ptr  <= ptr_nx;
          written <= written_nx;
        end
        if (trig_hit)                        post_cnt <= CW'(1);
        else if (store && state == ST_POST)  post_cnt <= post_cnt + CW'(1);
        if (post_done) begin
          rd_addr    <= ptr_nx - written_nx[AW-1:0];
          issue_left <= written_nx;
        end
        if (issue) begin
          rd_addr    <= rd_addr + AW'(1);
          issue_left <= issue_left - CW'(1);
        end
        if (issue)         q_valid <= 1'b1;
        else if (out_take) q_valid <= 1'b0;
        if (out_take) begin
          bus.rd_valid <= q_valid;
          if (q_valid) bus.rd_data <= ram_q;
        end
      end
    end
  end

  assign state_o = state;
  assign count_o = written;

  rv_trace_capture_trace_ram #(.DEPTH(DEPTH), .WIDTH(TRACE_W)) u_ram (
    .clk   (clk),
    .we    (store),
    .waddr (wr_ptr),
    .wdata (cur),
    .re    (issue),
    .raddr (rd_addr),
    .rdata (ram_q)
  );
endmodule

// File: tb/tb_rv_trace_capture.sv
// Self-checking bench for rv_trace_capture against a queue-based capture model.
module tb_rv_trace_capture;
  import rv_trace_capture_pkg::*;

  localparam int DEPTH    = 64;
  localparam int PRE_TRIG = 16;
  localparam int POST_N   = DEPTH - PRE_TRIG;
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int ENT_LO   = ILA_PROBE_W - 2 - AW - CW - 1 - TRACE_W;

  logic clk = 1'b0, rst_n = 1'b0, arm = 1'b0, trig_en = 1'b0;
  logic [31:0]            trig_pc = '0;
  logic [1:0]             state_o;
  logic [CW-1:0]          count_o;
  logic [ILA_PROBE_W-1:0] ila_probe0;
  logic [31:0]            ila_trig;
  logic [31:0]            cyc;

  rv_trace_capture_if bus();

  rv_trace_capture #(.DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .state_o(state_o), .count_o(count_o), .ila_probe0(ila_probe0), .ila_trig(ila_trig)
  );

  int errors = 0, checks = 0;
  logic [TRACE_W-1:0] mq[$], got[$], last_e;
  bit m_cap = 0, m_trig = 0;
  int m_post = 0;

  always #5 clk = ~clk;
  // Reference free-running timestamp: counts rising edges since reset release.
  always @(posedge clk or negedge rst_n) if (!rst_n) cyc <= '0; else cyc <= cyc + 32'd1;

  function automatic logic [31:0] rnd_pc();
    logic [31:0] r;
    r = $urandom;
    r[1:0] = 2'b10;
    return r;
  endfunction

  function automatic logic [31:0] pc_of(input logic [TRACE_W-1:0] e);
    return e[101:70];
  endfunction

  task automatic model_arm();
    mq.delete(); m_cap = 1; m_trig = 0; m_post = 0;
  endtask

  task automatic model_commit(input logic [TRACE_W-1:0] e);
    if (!m_cap) return;
    mq.push_back(e);
    if (!m_trig && trig_en && pc_of(e) == trig_pc) begin m_trig = 1; m_post = 1; end
    else if (m_trig) m_post++;
    if (m_trig && m_post == POST_N) m_cap = 0;
  endtask

  task automatic step(input bit v, input logic [31:0] pc);
    bus.commit_valid = v;
    bus.commit_pc    = pc;
    bus.commit_instr = $urandom;
    bus.commit_wdata = $urandom;
    bus.commit_rd    = 5'($urandom);
    bus.commit_we    = 1'($urandom);
    last_e = {cyc, pc, bus.commit_instr, bus.commit_wdata, bus.commit_rd, bus.commit_we};
    if (v) model_commit(last_e);
    @(posedge clk); #1;
  endtask

  task automatic do_arm();
    arm = 1; bus.commit_valid = 1; bus.commit_pc = trig_pc;
    @(posedge clk); #1;
    arm = 0; bus.commit_valid = 0;
    model_arm();
  endtask

  task automatic drain(input bit toggle);
    logic [TRACE_W-1:0] exp_q[$], hold_d;
    int n, first_k, last_k;
    bit held;
    n = (mq.size() > DEPTH) ? DEPTH : mq.size();
    for (int i = mq.size() - n; i < mq.size(); i++) exp_q.push_back(mq[i]);
    got.delete(); first_k = -1; last_k = -1; held = 0; hold_d = '0;
    checks++;
    if (state_o !== 2'd3) begin errors++; $display("FAIL drain_enter: state %0d required 3", state_o); end
    for (int k = 0; k < 4 * n + 10 && exp_q.size() > 0; k++) begin
      if (held) begin
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== hold_d) begin
          errors++; $display("FAIL stall_hold: valid %b data %h required 1 %h", bus.rd_valid, bus.rd_data, hold_d);
        end
      end
      if (first_k < 0 && bus.rd_valid === 1'b1) begin
        first_k = k; checks++;
        if (k != 2) begin errors++; $display("FAIL first_valid_latency: %0d cycles required 2", k); end
      end
      bus.rd_ready = toggle ? k[0] : 1'b1;
      held   = bus.rd_valid && !bus.rd_ready;
      hold_d = bus.rd_data;
      if (bus.rd_valid === 1'b1 && bus.rd_ready) begin
        got.push_back(bus.rd_data); checks++;
        if (bus.rd_data !== exp_q[0]) begin
          errors++; $display("FAIL drain_entry %0d: got %h required %h", got.size() - 1, bus.rd_data, exp_q[0]);
        end
        void'(exp_q.pop_front()); last_k = k;
      end
      step($urandom_range(0, 1) != 0, rnd_pc());
    end
    bus.rd_ready = 0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drain_timeout: %0d entries missing of %0d", exp_q.size(), n); end
    checks++;
    if (bus.rd_valid !== 1'b0 || state_o !== 2'd0) begin
      errors++; $display("FAIL drain_exit: valid %b state %0d required 0 0", bus.rd_valid, state_o);
    end
    if (!toggle) begin
      checks++;
      if (last_k - first_k + 1 != n) begin errors++; $display("FAIL back_to_back: %0d cycles for %0d entries", last_k - first_k + 1, n); end
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (state_o !== 2'd0 || count_o !== '0 || bus.rd_valid !== 1'b0 || bus.rd_data !== '0 ||
        ila_probe0 !== '0 || ila_trig !== '0) begin
      errors++;
      $display("FAIL %s: state %0d count %0d valid %b data %h trig %h probe_nz %b required all 0",
               tag, state_o, count_o, bus.rd_valid, bus.rd_data, ila_trig, |ila_probe0);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 check_zero("reset_values");
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (state_o !== 2'd0 || bus.rd_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: state %0d valid %b required 0 0", state_o, bus.rd_valid); end
  endtask

  task automatic test_armed_no_trig();
    trig_en = 0;
    do_arm();
    checks++;
    if (state_o !== 2'd1 || count_o !== '0) begin errors++; $display("FAIL arm_enter: state %0d count %0d required 1 0", state_o, count_o); end
    for (int i = 0; i < 10; i++) begin
      step(1, rnd_pc());
      checks++;
      if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL armed_rd_valid: got %b required 0", bus.rd_valid); end
    end
    checks++;
    if (state_o !== 2'd1 || count_o !== CW'(10)) begin errors++; $display("FAIL armed_count: state %0d count %0d required 1 10", state_o, count_o); end
  endtask

  task automatic test_pc_trigger();
    logic [1:0] exp_st;
    trig_en = 1; trig_pc = 32'h1A0;
    do_arm();
    for (int i = 0; i <= 87; i++) begin
      step(1, 32'h100 + 32'(4 * i));
      exp_st = (i < 40) ? 2'd1 : (i < 87) ? 2'd2 : 2'd3;
      checks++;
      if (state_o !== exp_st) begin errors++; $display("FAIL trig_state i=%0d: got %0d required %0d", i, state_o, exp_st); end
      if (i == 40) begin
        checks++;
        if (ila_trig !== 32'd1) begin errors++; $display("FAIL ila_trig_pulse: got %h required 1", ila_trig); end
        checks++;
        if (ila_probe0[ENT_LO +: TRACE_W] !== last_e || ila_probe0[ENT_LO + TRACE_W] !== 1'b1 ||
            ila_probe0[ENT_LO + TRACE_W + 1 +: CW] !== CW'(40) ||
            ila_probe0[ENT_LO + TRACE_W + 1 + CW +: AW] !== AW'(40) || ila_probe0[ILA_PROBE_W-2 +: 2] !== 2'd1) begin
          errors++; $display("FAIL ila_probe_trig: got %h", ila_probe0[ILA_PROBE_W-1:ENT_LO]);
        end
      end
      if (i == 41) begin
        checks++;
        if (ila_trig !== 32'd0) begin errors++; $display("FAIL ila_trig_once: got %h required 0", ila_trig); end
      end
    end
    checks++;
    if (count_o !== CW'(DEPTH)) begin errors++; $display("FAIL full_count: got %0d required %0d", count_o, DEPTH); end
    drain(0);
    checks++;
    if (got.size() != DEPTH || pc_of(got[16]) !== 32'h1A0 || pc_of(got[0]) !== 32'h160) begin
      errors++; $display("FAIL trig_window: n=%0d required 64 with pc 0x160 first, 0x1A0 at 16", got.size());
    end
  endtask

  task automatic test_early_trigger();
    logic [31:0] p0;
    int n;
    trig_pc = $urandom; trig_pc[1:0] = 2'b00;
    do_arm();
    p0 = rnd_pc();
    step(1, p0); step(0, rnd_pc()); step(1, rnd_pc()); step(1, trig_pc);
    checks++;
    if (state_o !== 2'd2) begin errors++; $display("FAIL early_post: state %0d required 2", state_o); end
    n = 0;
    while (m_cap && n < 500) begin step($urandom_range(0, 2) != 0, rnd_pc()); n++; end
    drain(0);
    checks++;
    if (got.size() != 2 + POST_N || pc_of(got[0]) !== p0) begin
      errors++; $display("FAIL early_window: n=%0d first pc %h required %0d and %h", got.size(), pc_of(got[0]), 2 + POST_N, p0);
    end
  endtask

  task automatic test_stall_drain();
    int n;
    trig_pc = $urandom; trig_pc[1:0] = 2'b00;
    do_arm();
    for (int i = 0; i < 70; i++) step($urandom_range(0, 3) != 0, rnd_pc());
    step(1, trig_pc);
    n = 0;
    while (m_cap && n < 500) begin step($urandom_range(0, 3) != 0, rnd_pc()); n++; end
    drain(1);
  endtask

  task automatic test_arm_abort();
    int n;
    trig_pc = $urandom; trig_pc[1:0] = 2'b00;
    do_arm();
    for (int i = 0; i < 20; i++) step(1, rnd_pc());
    step(1, trig_pc);
    for (int i = 0; i < 5; i++) step(1, rnd_pc());
    checks++;
    if (state_o !== 2'd2) begin errors++; $display("FAIL abort_pre_post: state %0d required 2", state_o); end
    do_arm();
    checks++;
    if (state_o !== 2'd1 || count_o !== '0 || bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL arm_mid_post: state %0d count %0d valid %b required 1 0 0", state_o, count_o, bus.rd_valid);
    end
    step(1, trig_pc);
    n = 0;
    while (m_cap && n < 500) begin step(1, rnd_pc()); n++; end
    for (int k = 0; k < 5 && bus.rd_valid !== 1'b1; k++) step(0, rnd_pc());
    checks++;
    if (bus.rd_valid !== 1'b1 || state_o !== 2'd3) begin errors++; $display("FAIL abort_pre_drain: valid %b state %0d required 1 3", bus.rd_valid, state_o); end
    bus.rd_ready = 1; step(0, rnd_pc()); bus.rd_ready = 0;
    do_arm();
    checks++;
    if (state_o !== 2'd1 || count_o !== '0 || bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL arm_mid_drain: state %0d count %0d valid %b required 1 0 0", state_o, count_o, bus.rd_valid);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] p;
    int n;
    trig_pc = $urandom; trig_pc[1:0] = 2'b00;
    do_arm();
    for (int i = 0; i < 30; i++) step(1, rnd_pc());
    step(1, trig_pc);
    for (int i = 0; i < 5; i++) step(1, rnd_pc());
    #3 rst_n = 0;
    #1 check_zero("async_reset");
    m_cap = 0; mq.delete();
    @(negedge clk) rst_n = 1;
    p = rnd_pc();
    bus.commit_valid = 1; bus.commit_pc = p;
    @(posedge clk); #1;
    checks++;
    if (ila_probe0[ENT_LO + 102 +: 32] !== 32'd0 || ila_probe0[ENT_LO + 70 +: 32] !== p) begin
      errors++; $display("FAIL ts_restart: ts %h pc %h required 0 %h", ila_probe0[ENT_LO + 102 +: 32], ila_probe0[ENT_LO + 70 +: 32], p);
    end
    do_arm();
    step(1, trig_pc);
    n = 0;
    while (m_cap && n < 500) begin step($urandom_range(0, 1) != 0, rnd_pc()); n++; end
    drain(0);
  endtask

  initial begin
    bus.commit_valid = 0; bus.commit_pc = '0; bus.commit_instr = '0; bus.commit_rd = '0;
    bus.commit_we = 0; bus.commit_wdata = '0; bus.rd_ready = 0;
    test_reset();
    test_armed_no_trig();
    test_pc_trigger();
    test_early_trigger();
    test_stall_drain();
    test_arm_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
